link_constraint: RTL and testbench
==================================

// Module: link_constraint
// PURPOSE
//  Distance-constraint solver for one rope/cloth link between two Node instances.
//  Reads the current positions of nodes A and B (their out_x/out_y).
//  Computes corrected positions that pull the pair back toward REST_LEN, and writes them to the nodes' fix_x/fix_y.
//  Multi-cycle and sequential: bit-serial integer sqrt, then two parallel restoring dividers.
//  The sequencer starts it once per link during the fix_constraint phase.
// PARAMETERS
//  REST_LEN  20  rest length of the link in coordinate units (unsigned, 1..32767)
//  COORD_W   32  width of every coordinate port
// PORTS
//  clk      in   1        single clock, all logic on posedge
//  reset    in   1        synchronous, active-high
//  start    in   1        request; sampled only in IDLE
//  a_x,a_y  in   COORD_W  position of node A (unsigned)
//  b_x,b_y  in   COORD_W  position of node B (unsigned)
//  busy     out  1        high in every state except IDLE
//  done     out  1        one-cycle pulse; fix_* valid from this cycle until the next done
//  fix_ax,fix_ay  out  COORD_W  corrected A position
//  fix_bx,fix_by  out  COORD_W  corrected B position
// BEHAVIOUR
//  Clock and reset:
//  - One clock (clk); reset is synchronous and active-high.
//  - Reset (also mid-operation): state goes to IDLE; busy=0, done=0, all fix_*=0; any in-flight job is discarded.
//  FSM: IDLE -> LOAD -> SQRT(16) -> CHECK -> {DIV(32) -> WRITE | WRITE} -> IDLE.
//  Cycle-level timing (let edge N sample start=1 in IDLE):
//  - Edge N: capture a_*, b_*.
//  - Edge N+1 (LOAD): dx=b_x-a_x, dy=b_y-a_y (signed), each clamped to [-32767,32767]; d2=dx*dx+dy*dy.
//  - Edges N+2..N+17 (SQRT): 16 iterations produce d=floor(sqrt(d2)).
//  - Edge N+18 (CHECK): correction is required only if d>REST_LEN; this also covers d==0.
//  - Correction path: DIV runs edges N+19..N+50; WRITE at edge N+51.
//  - No-correction path: WRITE at edge N+19.
//  Correction arithmetic:
//  - e=d-REST_LEN.
//  - |cx|=floor(|dx|*e/(2*d)), |cy| likewise; the sign is that of dx/dy, i.e. truncation toward zero.
//  - fix_ax=a_x+cx, fix_ay=a_y+cy, fix_bx=b_x-cx, fix_by=b_y-cy, all modulo 2^COORD_W.
//  No-correction result: fix_a*=a_*, fix_b*=b_*, unchanged.
//  After WRITE:
//  - fix_* update at the WRITE edge; done=1 and busy=0 in the following cycle (FSM is back in IDLE).
//  - start=1 in that same done cycle is accepted, so back-to-back jobs are allowed.
//  Input handling:
//  - start while busy is ignored; no queueing.
//  - Input changes after edge N have no effect on the running job.
//  - fix_* hold their value between jobs.
//  Widths: products fit in 31 bits; the divisor 2d fits in 17 bits; quotients fit in 16 bits.
// TESTING (REST_LEN=20)
//  1. a=(200,10), b=(200,40) -> d=30, cy=5; done at N+52; fix_a=(200,15), fix_b=(200,35).
//  2. a=(200,10), b=(200,25) -> d=15, no correction; done at N+20; fix_a=(200,10), fix_b=(200,25).
//  3. a=(100,100), b=(130,140) -> d=50, cx=9, cy=12; fix_a=(109,112), fix_b=(121,128).
//  4. a=(130,140), b=(100,100) -> negative deltas, truncate toward zero; fix_a=(121,128), fix_b=(109,112).
//  5. Pulse reset at N+25 -> busy=0 next cycle, no done, fix_*=0; a fresh start then gives a correct result.
//  6. Hold start=1 through a job, with a==b -> second job starts in the done cycle; a==b (d=0) returns inputs unchanged.

Source files
------------

// File: rtl/link_constraint.sv
// link_constraint: distance-constraint solver for one rope/cloth link.
// Reads node positions A and B, computes d = floor(sqrt(dx^2+dy^2)) with a
// bit-serial square root, and if d exceeds REST_LEN pulls both nodes toward
// each other by half the excess using two parallel restoring dividers.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   start                 job request, sampled only while idle
//   a_x, a_y, b_x, b_y    node positions (unsigned, COORD_W bits)
//   busy                  high whenever the solver is not idle
//   done                  one-cycle pulse; fix_* valid from here until next done
//   fix_ax .. fix_by      corrected node positions
module link_constraint #(
  parameter int unsigned REST_LEN = 20,
  parameter int unsigned COORD_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] a_x,
  input  logic [COORD_W-1:0] a_y,
  input  logic [COORD_W-1:0] b_x,
  input  logic [COORD_W-1:0] b_y,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] fix_ax,
  output logic [COORD_W-1:0] fix_ay,
  output logic [COORD_W-1:0] fix_bx,
  output logic [COORD_W-1:0] fix_by
);

  localparam int unsigned MAG_W   = 15;  // clamped |dx|, |dy|
  localparam int unsigned ROOT_W  = 16;  // d
  localparam int unsigned RAD_W   = 32;  // d2 and dividends
  localparam int unsigned SREM_W  = 18;  // sqrt partial remainder
  localparam int unsigned DIVR_W  = 17;  // divisor 2d and divider remainder
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned DIFF_W  = COORD_W + 1;

  localparam logic [CNT_W-1:0]  SQRT_LAST = CNT_W'(15);
  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(31);
  localparam logic [ROOT_W-1:0] REST      = ROOT_W'(REST_LEN);

  localparam logic signed [DIFF_W-1:0] LIM_P = DIFF_W'(32767);
  localparam logic signed [DIFF_W-1:0] LIM_N = -LIM_P;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SQRT,
    S_CHECK,
    S_DIV,
    S_WRITE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q;
  logic [COORD_W-1:0] ax_q, ay_q, bx_q, by_q;
  logic [MAG_W-1:0]   adx_q, ady_q;
  logic               sx_q, sy_q;
  logic [RAD_W-1:0]   rad_q;
  logic [SREM_W-1:0]  srem_q;
  logic [ROOT_W-1:0]  root_q;
  logic [DIVR_W-1:0]  divisor_q;
  logic [RAD_W-1:0]   qx_q, qy_q;
  logic [DIVR_W-1:0]  rx_q, ry_q;
  logic               corr_q;

  // Signed delta clamped to +/-32767, returned as {negative, magnitude}.
  function automatic logic [MAG_W:0] clamp_delta(input logic signed [DIFF_W-1:0] v);
    logic [MAG_W:0] r;
    if (v > LIM_P)        r = {1'b0, {MAG_W{1'b1}}};
    else if (v < LIM_N)   r = {1'b1, {MAG_W{1'b1}}};
    else if (v[DIFF_W-1]) r = {1'b1, MAG_W'(-v)};
    else                  r = {1'b0, MAG_W'(v)};
    return r;
  endfunction

  // One restoring-division step: returns {remainder, quotient/dividend shift reg}.
  function automatic logic [DIVR_W+RAD_W-1:0] div_step(input logic [DIVR_W-1:0] r,
                                                       input logic [RAD_W-1:0]  q,
                                                       input logic [DIVR_W-1:0] dv);
    logic [DIVR_W:0]             sh;
    logic [DIVR_W+RAD_W-1:0]     res;
    sh = {r, q[RAD_W-1]};
    if (sh >= {1'b0, dv}) res = {DIVR_W'(sh - {1'b0, dv}), q[RAD_W-2:0], 1'b1};
    else                  res = {sh[DIVR_W-1:0], q[RAD_W-2:0], 1'b0};
    return res;
  endfunction

  // Deltas and squared distance from the captured positions.
  logic signed [DIFF_W-1:0] dxw_c, dyw_c;
  logic [MAG_W:0]           cdx_c, cdy_c;
  logic [RAD_W-1:0]         d2_c;

  always_comb begin
    dxw_c = $signed({1'b0, bx_q}) - $signed({1'b0, ax_q});
    dyw_c = $signed({1'b0, by_q}) - $signed({1'b0, ay_q});
    cdx_c = clamp_delta(dxw_c);
    cdy_c = clamp_delta(dyw_c);
    d2_c  = RAD_W'(cdx_c[MAG_W-1:0]) * RAD_W'(cdx_c[MAG_W-1:0])
          + RAD_W'(cdy_c[MAG_W-1:0]) * RAD_W'(cdy_c[MAG_W-1:0]);
  end

  // Square-root step: bring down two radicand bits, try subtracting 4*root+1.
  logic [SREM_W+1:0] s_sh_c, s_trial_c;
  logic              s_ge_c;

  always_comb begin
    s_sh_c    = {srem_q, rad_q[RAD_W-1:RAD_W-2]};
    s_trial_c = {2'b00, root_q, 2'b01};
    s_ge_c    = (s_sh_c >= s_trial_c);
  end

  // Correction setup: excess length and the two dividends.
  logic              need_corr_c;
  logic [ROOT_W-1:0] excess_c;

  always_comb begin
    need_corr_c = (root_q > REST);
    excess_c    = root_q - REST;
  end

  // Divider steps for both axes.
  logic [DIVR_W+RAD_W-1:0] dstep_x_c, dstep_y_c;

  always_comb begin
    dstep_x_c = div_step(rx_q, qx_q, divisor_q);
    dstep_y_c = div_step(ry_q, qy_q, divisor_q);
  end

  // Final per-axis correction magnitudes (zero on the no-correction path).
  logic [COORD_W-1:0] cx_c, cy_c;

  always_comb begin
    cx_c = '0;
    cy_c = '0;
    if (corr_q) begin
      cx_c = COORD_W'(qx_q[ROOT_W-1:0]);
      cy_c = COORD_W'(qy_q[ROOT_W-1:0]);
    end
  end

  // State register and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != S_IDLE);
      done    <= (state_q == S_WRITE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = S_SQRT;
      S_SQRT:  if (cnt_q == SQRT_LAST) state_d = S_CHECK;
      S_CHECK: state_d = need_corr_c ? S_DIV : S_WRITE;
      S_DIV:   if (cnt_q == DIV_LAST) state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      ax_q      <= '0;
      ay_q      <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      adx_q     <= '0;
      ady_q     <= '0;
      sx_q      <= 1'b0;
      sy_q      <= 1'b0;
      rad_q     <= '0;
      srem_q    <= '0;
      root_q    <= '0;
      divisor_q <= '0;
      qx_q      <= '0;
      qy_q      <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
      corr_q    <= 1'b0;
      fix_ax    <= '0;
      fix_ay    <= '0;
      fix_bx    <= '0;
      fix_by    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ax_q <= a_x;
            ay_q <= a_y;
            bx_q <= b_x;
            by_q <= b_y;
          end
        end
        S_LOAD: begin
          adx_q  <= cdx_c[MAG_W-1:0];
          ady_q  <= cdy_c[MAG_W-1:0];
          sx_q   <= cdx_c[MAG_W];
          sy_q   <= cdy_c[MAG_W];
          rad_q  <= d2_c;
          srem_q <= '0;
          root_q <= '0;
          cnt_q  <= '0;
        end
        S_SQRT: begin
          if (s_ge_c) begin
            srem_q <= SREM_W'(s_sh_c - s_trial_c);
            root_q <= {root_q[ROOT_W-2:0], 1'b1};
          end else begin
            srem_q <= SREM_W'(s_sh_c);
            root_q <= {root_q[ROOT_W-2:0], 1'b0};
          end
          rad_q <= {rad_q[RAD_W-3:0], 2'b00};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_CHECK: begin
          corr_q    <= need_corr_c;
          divisor_q <= {root_q, 1'b0};
          qx_q      <= RAD_W'(adx_q) * RAD_W'(excess_c);
          qy_q      <= RAD_W'(ady_q) * RAD_W'(excess_c);
          rx_q      <= '0;
          ry_q      <= '0;
          cnt_q     <= '0;
        end
        S_DIV: begin
          rx_q  <= dstep_x_c[DIVR_W+RAD_W-1:RAD_W];
          qx_q  <= dstep_x_c[RAD_W-1:0];
          ry_q  <= dstep_y_c[DIVR_W+RAD_W-1:RAD_W];
          qy_q  <= dstep_y_c[RAD_W-1:0];
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_WRITE: begin
          // A moves toward B and B toward A; sign follows the delta.
          fix_ax <= sx_q ? (ax_q - cx_c) : (ax_q + cx_c);
          fix_ay <= sy_q ? (ay_q - cy_c) : (ay_q + cy_c);
          fix_bx <= sx_q ? (bx_q + cx_c) : (bx_q - cx_c);
          fix_by <= sy_q ? (by_q + cy_c) : (by_q - cy_c);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_link_constraint.sv
// Testbench for link_constraint (REST_LEN=20): directed jobs with a
// scoreboard queue of expected results and done timing.
module tb_link_constraint;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a_x, a_y, b_x, b_y;
  logic        busy, done;
  logic [31:0] fix_ax, fix_ay, fix_bx, fix_by;

  link_constraint #(.REST_LEN(20), .COORD_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a_x    (a_x),
    .a_y    (a_y),
    .b_x    (b_x),
    .b_y    (b_y),
    .busy   (busy),
    .done   (done),
    .fix_ax (fix_ax),
    .fix_ay (fix_ay),
    .fix_bx (fix_bx),
    .fix_by (fix_by)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] ax, ay, bx, by;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  exp_t m_e;
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        m_e = sbq.pop_front();
        check("done_cycle", 32'(cyc), 32'(m_e.cyc));
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("fix_ax", fix_ax, m_e.ax);
        check("fix_ay", fix_ay, m_e.ay);
        check("fix_bx", fix_bx, m_e.bx);
        check("fix_by", fix_by, m_e.by);
      end
    end
  end

  // Directed vectors: a_x a_y b_x b_y | fix_ax fix_ay fix_bx fix_by, plus latency.
  logic [31:0] tv [0:6][0:7] = '{
    '{200, 10, 200, 40,    200, 15, 200, 35},
    '{200, 10, 200, 25,    200, 10, 200, 25},
    '{100, 100, 130, 140,  109, 112, 121, 128},
    '{130, 140, 100, 100,  121, 128, 109, 112},
    '{0, 0, 12, 16,        0, 0, 12, 16},
    '{0, 0, 21, 1,         0, 0, 21, 1},
    '{0, 0, 40000, 0,      16373, 0, 23627, 0}
  };
  int tl [0:6] = '{51, 19, 51, 51, 19, 51, 51};

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding after %0d cycles", sbq.size(), n);
      sbq.delete();
    end
  endtask

  task automatic run_job(input logic [31:0] ax, ay, bx, by,
                         input logic [31:0] eax, eay, ebx, eby, input int lat);
    exp_t e;
    @(negedge clk);
    a_x = ax; a_y = ay; b_x = bx; b_y = by;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.ax = eax; e.ay = eay; e.bx = ebx; e.by = eby; e.cyc = cyc + lat;
    sbq.push_back(e);
    start = 1'b0;
    // Inputs changing after capture must not disturb the job.
    a_x = $urandom; a_y = $urandom; b_x = $urandom; b_y = $urandom;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_drain();
  endtask

  initial begin
    exp_t e;
    int   c;
    reset = 1'b1;
    start = 1'b0;
    a_x = '0; a_y = '0; b_x = '0; b_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_fix_ax", fix_ax, 32'd0);
    check("reset_fix_ay", fix_ay, 32'd0);
    check("reset_fix_bx", fix_bx, 32'd0);
    check("reset_fix_by", fix_by, 32'd0);

    for (int i = 0; i < 7; i++)
      run_job(tv[i][0], tv[i][1], tv[i][2], tv[i][3],
              tv[i][4], tv[i][5], tv[i][6], tv[i][7], tl[i]);

    // Results hold between jobs.
    repeat (10) @(negedge clk);
    check("hold_fix_ax", fix_ax, 32'd16373);
    check("hold_fix_bx", fix_bx, 32'd23627);

    // Reset in the middle of a correction job: job discarded, outputs cleared.
    @(negedge clk);
    a_x = 100; a_y = 100; b_x = 130; b_y = 140;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_fix_ax", fix_ax, 32'd0);
    check("midrst_fix_ay", fix_ay, 32'd0);
    check("midrst_fix_bx", fix_bx, 32'd0);
    check("midrst_fix_by", fix_by, 32'd0);
    repeat (40) @(negedge clk);
    run_job(100, 100, 130, 140, 109, 112, 121, 128, 51);

    // start held high: second job accepted in the done cycle; a==b returns inputs.
    @(negedge clk);
    a_x = 50; a_y = 60; b_x = 50; b_y = 60;
    start = 1'b1;
    @(posedge clk);
    #1;
    c = cyc;
    e.ax = 50; e.ay = 60; e.bx = 50; e.by = 60; e.cyc = c + 19;
    sbq.push_back(e);
    e.ax = 70; e.ay = 80; e.bx = 70; e.by = 80; e.cyc = c + 20 + 19;
    sbq.push_back(e);
    a_x = 70; a_y = 80; b_x = 70; b_y = 80;
    repeat (20) @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_second_job", {31'd0, busy}, 32'd1);
    wait_drain();
    repeat (30) @(negedge clk);
    check("idle_after_b2b", {31'd0, busy}, 32'd0);
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
